// File: rtl/ifetch_queue.sv
// Decoupled fetch stage: issues sequential PCs to a pipelined in-order icache,
// buffers returned instructions in a DEPTH-entry queue and hands {instr, pc} to decode.
// A redirect flushes the queue and drops responses still in flight at that time.
module ifetch_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] reset_adr_i,
  output logic            icache_req_v_o,
  input  logic            icache_req_rdy_i,
  output logic [XLEN-1:0] icache_adr_o,
  input  logic            icache_rsp_v_i,
  input  logic [31:0]     icache_instr_i,
  input  logic            flush_v_q_i,
  input  logic [XLEN-1:0] pc_data_q_i,
  output logic            dec_v_o,
  input  logic            dec_rdy_i,
  output logic [31:0]     instr_q_o,
  output logic [XLEN-1:0] pc_q_o
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned CntW = CW + 1;

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_discard;
  logic [31:0]     r_instr_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem    [DEPTH];

  logic            w_run;
  logic            w_flush;
  logic            w_req_v;
  logic            w_req_acc;
  logic            w_drop;
  logic            w_push;
  logic            w_dec_v;
  logic            w_pop;
  logic [CW-1:0]   w_outst_nxt;
  logic [XLEN-1:0] w_boot_pc;
  logic [XLEN-1:0] w_flush_pc;
  logic [CntW-1:0] w_credit_used;

  // Handshake decode and credit accounting
  always_comb begin
    w_run         = (r_state == StRun);
    w_flush       = w_run & flush_v_q_i;
    // Outstanding includes responses already marked for discard, so they hold credit too
    w_credit_used = {1'b0, r_count} + {1'b0, r_outst};
    w_req_v       = w_run & ~flush_v_q_i & (w_credit_used < CntW'(DEPTH));
    w_req_acc     = w_req_v & icache_req_rdy_i;
    w_drop        = icache_rsp_v_i & ((r_discard != '0) | w_flush);
    w_push        = icache_rsp_v_i & ~w_drop;
    w_dec_v       = (r_count != '0) & ~w_flush;
    w_pop         = w_dec_v & dec_rdy_i;
    w_outst_nxt   = r_outst + CW'(w_req_acc) - CW'(icache_rsp_v_i);
    w_boot_pc     = reset_adr_i & ~(XLEN'(3));
    w_flush_pc    = pc_data_q_i & ~(XLEN'(3));
  end

  // Control state: FSM, PCs, pointers and counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= StBoot;
      r_fetch_pc <= '0;
      r_rsp_pc   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (r_state == StBoot) begin
        r_fetch_pc <= w_boot_pc;
        r_rsp_pc   <= w_boot_pc;
        r_state    <= StRun;
      end else if (w_flush) begin
        r_fetch_pc <= w_flush_pc;
        r_rsp_pc   <= w_flush_pc;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        // Everything still in flight belongs to the old path
        r_discard  <= w_outst_nxt;
      end else begin
        if (w_req_acc) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push) begin
          r_tail   <= r_tail + PW'(1);
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
        end
        if (w_pop) r_head <= r_head + PW'(1);
        if (w_push && !w_pop) r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        if (w_drop) r_discard <= r_discard - CW'(1);
      end
    end
  end

  // Queue storage; contents are only observed when the count says an entry is valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_tail] <= icache_instr_i;
      r_pc_mem[r_tail]    <= r_rsp_pc;
    end
  end

  // Output drive; head data is zeroed while not valid
  always_comb begin
    icache_req_v_o = w_req_v;
    icache_adr_o   = r_fetch_pc;
    dec_v_o        = w_dec_v;
    instr_q_o      = w_dec_v ? r_instr_mem[r_head] : '0;
    pc_q_o         = w_dec_v ? r_pc_mem[r_head] : '0;
  end

`ifndef SYNTHESIS
  // Credit scheme must never let a response land in a full queue without a pop
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_push && !w_pop && (r_count == CW'(DEPTH))));
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: queue-based reference model plus directed scenarios.
module tb_ifetch_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] IKEY  = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] reset_adr_i;
  logic        icache_req_v_o;
  logic        icache_req_rdy_i;
  logic [31:0] icache_adr_o;
  logic        icache_rsp_v_i;
  logic [31:0] icache_instr_i;
  logic        flush_v_q_i;
  logic [31:0] pc_data_q_i;
  logic        dec_v_o;
  logic        dec_rdy_i;
  logic [31:0] instr_q_o;
  logic [31:0] pc_q_o;

  always #5 clk = ~clk;

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .reset_adr_i      (reset_adr_i),
    .icache_req_v_o   (icache_req_v_o),
    .icache_req_rdy_i (icache_req_rdy_i),
    .icache_adr_o     (icache_adr_o),
    .icache_rsp_v_i   (icache_rsp_v_i),
    .icache_instr_i   (icache_instr_i),
    .flush_v_q_i      (flush_v_q_i),
    .pc_data_q_i      (pc_data_q_i),
    .dec_v_o          (dec_v_o),
    .dec_rdy_i        (dec_rdy_i),
    .instr_q_o        (instr_q_o),
    .pc_q_o           (pc_q_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: fetch state plus a queue of {instr, pc}
  bit          m_run = 1'b0;
  logic [31:0] m_fetch_pc = '0;
  logic [31:0] m_rsp_pc = '0;
  logic [63:0] m_q[$];
  int          m_outst = 0;
  int          m_discard = 0;

  // Icache model: accepted addresses and the cycle of acceptance
  logic [31:0] ic_adr[$];
  int          ic_cyc[$];

  // Stimulus knobs (percent probabilities)
  int          p_rdy = 100, p_rsp = 100, p_dec = 100, p_flush = 0;
  bit          use_fixed_tgt = 1'b0;
  logic [31:0] fixed_tgt = '0;
  logic [31:0] cur_reset_adr = 32'h8000_0000;

  logic        e_req_v, e_dec_v;
  logic [31:0] e_adr, e_instr, e_pc;

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive inputs mid-cycle, then compare outputs against the model
  task automatic cyc_begin(input bit rst);
    @(negedge clk);
    reset_n          = !rst;
    reset_adr_i      = cur_reset_adr;
    icache_req_rdy_i = roll(p_rdy);
    flush_v_q_i      = roll(p_flush);
    pc_data_q_i      = use_fixed_tgt ? fixed_tgt : $urandom();
    dec_rdy_i        = roll(p_dec);
    if (!rst && ic_adr.size() != 0 && ic_cyc[0] < cyc && roll(p_rsp)) begin
      icache_rsp_v_i = 1'b1;
      icache_instr_i = ic_adr[0] ^ IKEY;
    end else begin
      icache_rsp_v_i = 1'b0;
      icache_instr_i = $urandom();
    end
    #1;
    e_req_v = m_run && !flush_v_q_i && (m_q.size() + m_outst < DEPTH);
    e_adr   = m_fetch_pc;
    e_dec_v = (m_q.size() != 0) && !(m_run && flush_v_q_i);
    e_instr = '0;
    e_pc    = '0;
    if (e_dec_v) {e_instr, e_pc} = m_q[0];
    check("req_v", 64'(icache_req_v_o), 64'(e_req_v));
    check("adr",   64'(icache_adr_o),   64'(e_adr));
    check("dec_v", 64'(dec_v_o),        64'(e_dec_v));
    check("instr", 64'(instr_q_o),      64'(e_instr));
    check("pc",    64'(pc_q_o),         64'(e_pc));
  endtask

  // Advance the model across the clock edge using the driven inputs
  task automatic cyc_end();
    bit acc;
    bit rsp;
    @(posedge clk);
    acc = e_req_v && icache_req_rdy_i;
    rsp = icache_rsp_v_i;
    if (!reset_n) begin
      m_run = 1'b0;
      m_fetch_pc = '0;
      m_rsp_pc = '0;
      m_q.delete();
      m_outst = 0;
      m_discard = 0;
      ic_adr.delete();
      ic_cyc.delete();
    end else if (!m_run) begin
      m_fetch_pc = {reset_adr_i[31:2], 2'b00};
      m_rsp_pc   = m_fetch_pc;
      m_run      = 1'b1;
    end else begin
      if (rsp) begin
        void'(ic_adr.pop_front());
        void'(ic_cyc.pop_front());
      end
      if (acc) begin
        ic_adr.push_back(m_fetch_pc);
        ic_cyc.push_back(cyc);
      end
      if (flush_v_q_i) begin
        m_outst    = m_outst - int'(rsp);
        m_discard  = m_outst;
        m_q.delete();
        m_fetch_pc = {pc_data_q_i[31:2], 2'b00};
        m_rsp_pc   = m_fetch_pc;
      end else begin
        if (e_dec_v && dec_rdy_i) void'(m_q.pop_front());
        if (acc) begin
          m_fetch_pc = m_fetch_pc + 32'd4;
          m_outst++;
        end
        if (rsp) begin
          m_outst--;
          if (m_discard > 0) m_discard--;
          else begin
            m_q.push_back({icache_instr_i, m_rsp_pc});
            m_rsp_pc = m_rsp_pc + 32'd4;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic step(input bit rst);
    cyc_begin(rst);
    cyc_end();
  endtask

  // Run until decode shows its first entry, then pin it to a literal PC
  task automatic wait_first_dec(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc_begin(1'b0);
      if (dec_v_o === 1'b1) begin
        found = 1'b1;
        check({name, "_pc"},    64'(pc_q_o),    64'(exp_pc));
        check({name, "_instr"}, 64'(instr_q_o), 64'(exp_pc ^ IKEY));
      end
      cyc_end();
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no dec_v within 20 cycles, required pc %h", name, exp_pc);
    end
  endtask

  task automatic do_reset(input logic [31:0] adr);
    cur_reset_adr = adr;
    step(1'b1);
    step(1'b1);
  endtask

  initial begin
    reset_n = 1'b0; reset_adr_i = '0; icache_req_rdy_i = 1'b0; icache_rsp_v_i = 1'b0;
    icache_instr_i = '0; flush_v_q_i = 1'b0; pc_data_q_i = '0; dec_rdy_i = 1'b0;

    // Sequential fetch with an always-ready icache and decode
    do_reset(32'h8000_0000);
    cyc_begin(1'b0);
    check("boot_req_v", 64'(icache_req_v_o), 64'd0);
    check("boot_adr",   64'(icache_adr_o),   64'd0);
    check("boot_dec_v", 64'(dec_v_o),        64'd0);
    check("boot_pc",    64'(pc_q_o),         64'd0);
    cyc_end();
    cyc_begin(1'b0);
    check("run1_req_v", 64'(icache_req_v_o), 64'd1);
    check("run1_adr",   64'(icache_adr_o),   64'h8000_0000);
    cyc_end();
    cyc_begin(1'b0);
    check("run2_adr",   64'(icache_adr_o),   64'h8000_0004);
    check("run2_dec_v", 64'(dec_v_o),        64'd0);
    cyc_end();
    cyc_begin(1'b0);
    check("run3_dec_v", 64'(dec_v_o),        64'd1);
    check("run3_pc",    64'(pc_q_o),         64'h8000_0000);
    check("run3_instr", 64'(instr_q_o),      64'(32'h8000_0000 ^ IKEY));
    check("run3_adr",   64'(icache_adr_o),   64'h8000_0008);
    cyc_end();
    for (int i = 0; i < 10; i++) step(1'b0);

    // Decode stalled: queue fills, requests stop, one pop frees one credit
    p_dec = 0;
    for (int i = 0; i < 12; i++) step(1'b0);
    cyc_begin(1'b0);
    check("full_req_v", 64'(icache_req_v_o), 64'd0);
    check("full_dec_v", 64'(dec_v_o),        64'd1);
    cyc_end();
    p_dec = 100;
    step(1'b0);
    p_dec = 0;
    cyc_begin(1'b0);
    check("pop_req_v1", 64'(icache_req_v_o), 64'd1);
    cyc_end();
    cyc_begin(1'b0);
    check("pop_req_v2", 64'(icache_req_v_o), 64'd0);
    cyc_end();
    p_dec = 100;
    for (int i = 0; i < 6; i++) step(1'b0);

    // Three requests in flight, then redirect to 0x100
    do_reset(32'h0000_2000);
    step(1'b0);
    p_rsp = 0;
    for (int i = 0; i < 3; i++) step(1'b0);
    p_flush = 100; use_fixed_tgt = 1'b1; fixed_tgt = 32'h0000_0100;
    cyc_begin(1'b0);
    check("fl3_req_v", 64'(icache_req_v_o), 64'd0);
    cyc_end();
    p_flush = 0; p_rsp = 100;
    cyc_begin(1'b0);
    check("fl3_next_req_v", 64'(icache_req_v_o), 64'd1);
    check("fl3_next_adr",   64'(icache_adr_o),   64'h100);
    cyc_end();
    wait_first_dec("fl3_first", 32'h0000_0100);

    // Flush together with a response and a pop while two entries are queued
    do_reset(32'h0000_3000);
    step(1'b0);
    p_dec = 0;
    for (int i = 0; i < 3; i++) step(1'b0);
    p_flush = 100; p_dec = 100; fixed_tgt = 32'h0000_4000;
    cyc_begin(1'b0);
    check("fl4_dec_v",  64'(dec_v_o),        64'd0);
    check("fl4_rsp_v",  64'(icache_rsp_v_i), 64'd1);
    cyc_end();
    p_flush = 0;
    cyc_begin(1'b0);
    check("fl4_next_dec_v", 64'(dec_v_o),      64'd0);
    check("fl4_next_adr",   64'(icache_adr_o), 64'h4000);
    cyc_end();
    wait_first_dec("fl4_first", 32'h0000_4000);

    // Stalled request holds its address; reset mid-stall restarts boot
    do_reset(32'h1234_567B);
    step(1'b0);
    p_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      cyc_begin(1'b0);
      check("stall_req_v", 64'(icache_req_v_o), 64'd1);
      check("stall_adr",   64'(icache_adr_o),   64'h1234_5678);
      cyc_end();
    end
    cur_reset_adr = 32'h0000_0A0C;
    step(1'b1);
    cyc_begin(1'b0);
    check("rst_req_v", 64'(icache_req_v_o), 64'd0);
    check("rst_adr",   64'(icache_adr_o),   64'd0);
    check("rst_dec_v", 64'(dec_v_o),        64'd0);
    cyc_end();
    cyc_begin(1'b0);
    check("reboot_adr", 64'(icache_adr_o), 64'h0000_0A0C);
    cyc_end();
    p_rdy = 100;

    // Address wrap and misaligned redirect target
    do_reset(32'hFFFF_FFF8);
    step(1'b0);
    cyc_begin(1'b0);
    check("wrap_adr0", 64'(icache_adr_o), 64'hFFFF_FFF8);
    cyc_end();
    cyc_begin(1'b0);
    check("wrap_adr1", 64'(icache_adr_o), 64'hFFFF_FFFC);
    cyc_end();
    cyc_begin(1'b0);
    check("wrap_adr2", 64'(icache_adr_o), 64'h0000_0000);
    cyc_end();
    p_flush = 100; fixed_tgt = 32'h0000_0103;
    step(1'b0);
    p_flush = 0;
    cyc_begin(1'b0);
    check("align_adr", 64'(icache_adr_o), 64'h0000_0100);
    cyc_end();
    use_fixed_tgt = 1'b0;

    // Randomised traffic with occasional resets
    for (int blk = 0; blk < 30; blk++) begin
      p_rdy   = int'($urandom_range(100));
      p_rsp   = int'($urandom_range(100));
      p_dec   = int'($urandom_range(100));
      p_flush = int'($urandom_range(8));
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(299) == 0) begin
          cur_reset_adr = $urandom();
          step(1'b1);
        end else begin
          step(1'b0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
